// File: rtl/digit_render_if.sv
// Digit offer channel for digit_render: digit code, box bounds, ready/valid handshake and busy.
interface digit_render_if;
  logic [3:0] digit_in;
  logic       digit_valid;
  logic       digit_ready;
  logic       busy;
  logic [8:0] Upper_data;
  logic [8:0] Lower_data;
  logic [8:0] Lift_data;
  logic [8:0] Right_data;

  modport master (
    output digit_in, digit_valid, Upper_data, Lower_data, Lift_data, Right_data,
    input  digit_ready, busy
  );

  modport slave (
    input  digit_in, digit_valid, Upper_data, Lower_data, Lift_data, Right_data,
    output digit_ready, busy
  );
endinterface

// File: rtl/digit_render.sv
// Renders one seven-segment digit into a scanned pixel stream; new digits
// are committed only at frame start so a frame never shows a mixed glyph.
module digit_render #(
  parameter logic [7:0]  FG         = 8'h00,
  parameter logic [7:0]  BG         = 8'hFF,
  parameter logic [8:0]  STROKE     = 9'd4,
  parameter int unsigned BLINK_LOG2 = 32'd5
) (
  input  logic          clock,
  input  logic          rst,
  input  logic          tft_begin,
  input  logic [8:0]    hcount,
  input  logic [8:0]    lcount,
  digit_render_if.slave dig,
  output logic [7:0]    data_out
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_SHOW    = 2'd2
  } state_t;

  localparam logic [8:0] STROKE_M1 = STROKE - 9'd1;
  localparam logic [9:0] MIN_H     = {STROKE, 1'b0};

  state_t state_r, state_s;
  logic capture_s, commit_s;
  logic digit_ready_r, busy_r, has_active_r;
  logic [BLINK_LOG2:0] frame_cnt_r;
  logic [3:0] pend_digit_r, act_digit_r;
  logic [8:0] pend_upper_r, pend_lower_r, pend_lift_r, pend_right_r;
  logic [8:0] act_upper_r, act_lower_r, act_lift_r, act_right_r;
  logic [7:0] data_out_r, pix_s;

  function automatic logic [8:0] sat_add(input logic [8:0] a, input logic [8:0] b);
    logic [9:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[9] ? 9'h1FF : s[8:0];
  endfunction

  function automatic logic [8:0] sat_sub(input logic [8:0] a, input logic [8:0] b);
    return (a >= b) ? (a - b) : 9'd0;
  endfunction

  function automatic logic in_range(input logic [8:0] v, input logic [8:0] lo, input logic [8:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  // Lit segments as {g,f,e,d,c,b,a}; invalid codes blink the middle bar.
  function automatic logic [6:0] seg_map(input logic [3:0] d, input logic blink_off);
    logic [6:0] m;
    case (d)
      4'd0:    m = 7'b0111111;
      4'd1:    m = 7'b0000110;
      4'd2:    m = 7'b1011011;
      4'd3:    m = 7'b1001111;
      4'd4:    m = 7'b1100110;
      4'd5:    m = 7'b1101101;
      4'd6:    m = 7'b1111101;
      4'd7:    m = 7'b0000111;
      4'd8:    m = 7'b1111111;
      4'd9:    m = 7'b1101111;
      default: m = blink_off ? 7'b0000000 : 7'b1000000;
    endcase
    return m;
  endfunction

  // Next-state logic for the offer/commit handshake.
  always_comb begin
    state_s   = state_r;
    capture_s = 1'b0;
    commit_s  = 1'b0;
    case (state_r)
      ST_IDLE, ST_SHOW: begin
        if (dig.digit_valid) begin
          state_s   = ST_PENDING;
          capture_s = 1'b1;
        end else begin
          state_s = state_r;
        end
      end
      ST_PENDING: begin
        if (tft_begin) begin
          state_s  = ST_SHOW;
          commit_s = 1'b1;
        end else begin
          state_s = ST_PENDING;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  logic [8:0] h_s, mid_s, a_hi_s, d_lo_s, g_hi_s, lf_hi_s, rt_lo_s;
  logic [6:0] seg_s, band_s;
  logic       degen_s, upper_rows_s, lower_rows_s, full_cols_s, left_cols_s, right_cols_s;

  // Band geometry from the active box; edges saturate instead of wrapping.
  always_comb begin
    h_s          = act_lower_r - act_upper_r;
    mid_s        = act_upper_r + {1'b0, h_s[8:1]};
    a_hi_s       = sat_add(act_upper_r, STROKE_M1);
    d_lo_s       = sat_sub(act_lower_r, STROKE_M1);
    g_hi_s       = sat_add(mid_s, STROKE_M1);
    lf_hi_s      = sat_add(act_lift_r, STROKE_M1);
    rt_lo_s      = sat_sub(act_right_r, STROKE_M1);
    degen_s      = (act_right_r <= act_lift_r) || (act_lower_r <= act_upper_r) || ({1'b0, h_s} < MIN_H);
    upper_rows_s = in_range(lcount, act_upper_r, mid_s);
    lower_rows_s = in_range(lcount, mid_s, act_lower_r);
    full_cols_s  = in_range(hcount, act_lift_r, act_right_r);
    left_cols_s  = in_range(hcount, act_lift_r, lf_hi_s);
    right_cols_s = in_range(hcount, rt_lo_s, act_right_r);
    band_s[0]    = in_range(lcount, act_upper_r, a_hi_s) && full_cols_s;
    band_s[1]    = right_cols_s && upper_rows_s;
    band_s[2]    = right_cols_s && lower_rows_s;
    band_s[3]    = in_range(lcount, d_lo_s, act_lower_r) && full_cols_s;
    band_s[4]    = left_cols_s && lower_rows_s;
    band_s[5]    = left_cols_s && upper_rows_s;
    band_s[6]    = in_range(lcount, mid_s, g_hi_s) && full_cols_s;
    seg_s        = seg_map(act_digit_r, frame_cnt_r[BLINK_LOG2]);
    if (has_active_r && !degen_s && (|(seg_s & band_s))) begin
      pix_s = FG;
    end else begin
      pix_s = BG;
    end
  end

  // State, handshake outputs, digit registers, frame counter and pixel register.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      digit_ready_r <= 1'b1;
      busy_r        <= 1'b0;
      has_active_r  <= 1'b0;
      frame_cnt_r   <= '0;
      pend_digit_r  <= 4'd0;
      pend_upper_r  <= 9'd0;
      pend_lower_r  <= 9'd0;
      pend_lift_r   <= 9'd0;
      pend_right_r  <= 9'd0;
      act_digit_r   <= 4'd0;
      act_upper_r   <= 9'd0;
      act_lower_r   <= 9'd0;
      act_lift_r    <= 9'd0;
      act_right_r   <= 9'd0;
      data_out_r    <= BG;
    end else begin
      state_r       <= state_s;
      digit_ready_r <= (state_s != ST_PENDING);
      busy_r        <= (state_s == ST_PENDING);
      data_out_r    <= pix_s;
      if (tft_begin) begin
        frame_cnt_r <= frame_cnt_r + {{BLINK_LOG2{1'b0}}, 1'b1};
      end
      if (capture_s) begin
        pend_digit_r <= dig.digit_in;
        pend_upper_r <= dig.Upper_data;
        pend_lower_r <= dig.Lower_data;
        pend_lift_r  <= dig.Lift_data;
        pend_right_r <= dig.Right_data;
      end
      if (commit_s) begin
        has_active_r <= 1'b1;
        act_digit_r  <= pend_digit_r;
        act_upper_r  <= pend_upper_r;
        act_lower_r  <= pend_lower_r;
        act_lift_r   <= pend_lift_r;
        act_right_r  <= pend_right_r;
      end
    end
  end

  assign dig.digit_ready = digit_ready_r;
  assign dig.busy        = busy_r;
  assign data_out        = data_out_r;

endmodule

// File: tb/tb_digit_render.sv
// Self-checking bench for digit_render: directed scenarios plus randomized
// traffic compared against a behavioural model of the rendered digit.
module tb_digit_render;

  localparam int FG_V = 8'h00;
  localparam int BG_V = 8'hFF;
  localparam int ST   = 4;
  localparam int BL   = 5;

  logic       clock = 1'b0;
  logic       rst = 1'b1;
  logic       tft_begin = 1'b0;
  logic [8:0] hcount = 9'd0;
  logic [8:0] lcount = 9'd0;
  logic [7:0] data_out;

  digit_render_if dif ();

  digit_render dut (
    .clock     (clock),
    .rst       (rst),
    .tft_begin (tft_begin),
    .hcount    (hcount),
    .lcount    (lcount),
    .dig       (dif),
    .data_out  (data_out)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: one pending slot, one active glyph, frame count modulo 2^(BL+1).
  bit m_pend = 1'b0;
  bit m_has  = 1'b0;
  int m_cnt  = 0;
  int p_dig, p_u, p_lo, p_lf, p_r;
  int a_dig, a_u, a_lo, a_lf, a_r;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic string seg_names(int d);
    case (d)
      0: return "abcdef";
      1: return "bc";
      2: return "abdeg";
      3: return "abcdg";
      4: return "bcfg";
      5: return "acdfg";
      6: return "acdefg";
      7: return "abc";
      8: return "abcdefg";
      9: return "abcdfg";
      default: return "g";
    endcase
  endfunction

  function automatic bit in_band(byte s, int h, int l, int mid);
    bit cols_full, cols_left, cols_right, rows_up, rows_dn;
    cols_full  = (h >= a_lf) && (h <= a_r);
    cols_left  = (h >= a_lf) && (h <= a_lf + ST - 1);
    cols_right = (h >= a_r - ST + 1) && (h <= a_r);
    rows_up    = (l >= a_u) && (l <= mid);
    rows_dn    = (l >= mid) && (l <= a_lo);
    case (s)
      "a": return cols_full && (l >= a_u) && (l <= a_u + ST - 1);
      "d": return cols_full && (l >= a_lo - ST + 1) && (l <= a_lo);
      "g": return cols_full && (l >= mid) && (l <= mid + ST - 1);
      "f": return cols_left && rows_up;
      "e": return cols_left && rows_dn;
      "b": return cols_right && rows_up;
      "c": return cols_right && rows_dn;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int model_pix(int h, int l);
    int ht, mid;
    string names;
    if (!m_has) return BG_V;
    ht = a_lo - a_u;
    if (a_r <= a_lf || a_lo <= a_u || ht < 2 * ST) return BG_V;
    mid = a_u + ht / 2;
    if (a_dig > 9 && ((m_cnt >> BL) % 2) == 1) return BG_V;
    names = seg_names(a_dig);
    for (int i = 0; i < names.len(); i++)
      if (in_band(names[i], h, l, mid)) return FG_V;
    return BG_V;
  endfunction

  task automatic set_offer(input bit v, input int d, input int u, input int lo, input int lf, input int r);
    dif.digit_valid = v;
    dif.digit_in    = d[3:0];
    dif.Upper_data  = u[8:0];
    dif.Lower_data  = lo[8:0];
    dif.Lift_data   = lf[8:0];
    dif.Right_data  = r[8:0];
  endtask

  // One clock: drive, predict from pre-edge model, advance, check all outputs.
  task automatic cycle(input bit t, input int hc, input int lc);
    int exp_pix, cd, cu, clo, clf, cr;
    bit acc;
    tft_begin = t;
    hcount    = hc[8:0];
    lcount    = lc[8:0];
    exp_pix   = rst ? BG_V : model_pix(hc, lc);
    acc       = dif.digit_valid && !m_pend;
    cd = int'(dif.digit_in); cu = int'(dif.Upper_data); clo = int'(dif.Lower_data);
    clf = int'(dif.Lift_data); cr = int'(dif.Right_data);
    @(posedge clock);
    #1;
    if (rst) begin
      m_pend = 1'b0; m_has = 1'b0; m_cnt = 0;
    end else begin
      if (m_pend && t) begin
        a_dig = p_dig; a_u = p_u; a_lo = p_lo; a_lf = p_lf; a_r = p_r;
        m_has = 1'b1; m_pend = 1'b0;
      end else if (acc) begin
        p_dig = cd; p_u = cu; p_lo = clo; p_lf = clf; p_r = cr;
        m_pend = 1'b1;
      end
      if (t) m_cnt = (m_cnt + 1) % (2 ** (BL + 1));
    end
    check_val("pixel", data_out, exp_pix);
    check_val("ready", dif.digit_ready, !m_pend);
    check_val("busy", dif.busy, m_pend);
  endtask

  task automatic pix(input int hc, input int lc, input int want);
    cycle(1'b0, hc, lc);
    check_val("spec_pixel", data_out, want);
  endtask

  task automatic load(input int d, input int u, input int lo, input int lf, input int r);
    set_offer(1'b1, d, u, lo, lf, r);
    cycle(1'b0, 0, 0);
    set_offer(1'b0, d, u, lo, lf, r);
    cycle(1'b1, 0, 0);
  endtask

  initial begin
    set_offer(1'b0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    cycle(1'b0, 0, 0);
    cycle(1'b0, 0, 0);
    check_val("reset_data", data_out, BG_V);
    check_val("reset_ready", dif.digit_ready, 1'b1);
    check_val("reset_busy", dif.busy, 1'b0);
    rst = 1'b0;
    cycle(1'b0, 25, 40);
    check_val("idle_bg", data_out, BG_V);

    // Digit 8 in the reference box, including the one-cycle lag.
    load(8, 20, 60, 10, 40);
    pix(10, 20, 8'h00); pix(40, 40, 8'h00); pix(25, 40, 8'h00);
    pix(25, 60, 8'h00); pix(25, 30, 8'hFF); pix(25, 20, 8'h00);

    // Digit 1: busy/ready over the whole wait for frame start.
    set_offer(1'b1, 1, 20, 60, 10, 40);
    cycle(1'b0, 0, 0);
    set_offer(1'b0, 1, 20, 60, 10, 40);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 25, 40);
      check_val("pend_busy", dif.busy, 1'b1);
      check_val("pend_ready", dif.digit_ready, 1'b0);
      check_val("pend_old_glyph", data_out, 8'h00);
    end
    cycle(1'b1, 0, 0);
    check_val("commit_busy", dif.busy, 1'b0);
    pix(12, 30, 8'hFF); pix(39, 30, 8'h00); pix(25, 20, 8'hFF);

    // Digit 3 showing; digit 7 offered mid-frame must wait.
    load(3, 20, 60, 10, 40);
    pix(25, 41, 8'h00);
    set_offer(1'b1, 7, 20, 60, 10, 40);
    cycle(1'b0, 0, 0);
    set_offer(1'b0, 7, 20, 60, 10, 40);
    pix(25, 41, 8'h00);
    cycle(1'b1, 0, 0);
    pix(25, 41, 8'hFF); pix(40, 30, 8'h00);

    // Invalid code 12 blinking over a full 64-frame blink period.
    load(12, 20, 60, 10, 40);
    for (int f = 0; f < 64; f++) begin
      cycle(1'b1, 0, 0);
      cycle(1'b0, 25, 41);
      cycle(1'b0, 25, 21);
      check_val("blink_other", data_out, 8'hFF);
    end

    // Degenerate box, then reset while pending.
    load(8, 50, 55, 10, 40);
    pix(25, 50, 8'hFF); pix(11, 52, 8'hFF);
    set_offer(1'b1, 8, 20, 60, 10, 40);
    cycle(1'b0, 0, 0);
    set_offer(1'b0, 8, 20, 60, 10, 40);
    rst = 1'b1;
    cycle(1'b0, 25, 20);
    rst = 1'b0;
    check_val("rst_pend_busy", dif.busy, 1'b0);
    check_val("rst_pend_ready", dif.digit_ready, 1'b1);
    cycle(1'b1, 0, 0);
    pix(25, 20, 8'hFF);

    // Low-edge clamp: right band would start below column 0.
    load(8, 0, 20, 0, 2);
    pix(0, 5, 8'h00); pix(2, 15, 8'h00);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      int u, lf;
      if ($urandom_range(0, 7) == 0) begin
        u  = $urandom_range(0, 60);
        lf = $urandom_range(0, 40);
        set_offer(1'b1, $urandom_range(0, 15), u, u + $urandom_range(0, 70),
                  lf, lf + $urandom_range(0, 50));
      end else begin
        dif.digit_valid = 1'b0;
      end
      rst = ($urandom_range(0, 599) == 0);
      cycle($urandom_range(0, 29) == 0, $urandom_range(0, 130), $urandom_range(0, 130));
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/digit_render.md
DIGIT_RENDER -- requirements
Module: digit_render

Interface
REQ-001 SHALL have parameter FG, default 8'h00, foreground (stroke) pixel value.
REQ-002 SHALL have parameter BG, default 8'hFF, background pixel value.
REQ-003 SHALL have parameter STROKE, default 9'd4, segment thickness in pixels.
REQ-004 SHALL have parameter BLINK_LOG2, default 5, invalid-digit blink half-period = 2^BLINK_LOG2 frames.
REQ-005 SHALL have port clock  input  1  sole clock; all logic rising-edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port tft_begin  input  1  one-cycle frame-start strobe.
REQ-008 SHALL have ports hcount, lcount  input  9 each  current scan column and row.
REQ-009 SHALL have ports Upper_data, Lower_data, Lift_data, Right_data  input  9 each  requested digit box, inclusive.
REQ-010 SHALL have port digit_in  input  4  digit code to draw.
REQ-011 SHALL have port digit_valid  input  1  digit_in and box are offered.
REQ-012 SHALL have port digit_ready  output  1  block accepts an offer this cycle.
REQ-013 SHALL have port data_out  output  8  rendered pixel.
REQ-014 SHALL have port busy  output  1  accepted digit waiting for frame start.

Function
REQ-015 SHALL implement FSM IDLE, PENDING, SHOW.
- Reset enters IDLE.
- Accept = digit_valid & digit_ready.
REQ-016 SHALL drive digit_ready=1 in IDLE and SHOW and 0 in PENDING.
REQ-017 On accept, SHALL capture digit_in and the four bounds into pending registers and go to PENDING.
REQ-018 In PENDING, SHALL on tft_begin copy the pending registers to the active registers and go to SHOW.
- busy=1 only in PENDING.
REQ-019 In SHOW, SHALL on accept go to PENDING.
- The active digit keeps displaying until the next tft_begin; no mid-frame change.
REQ-020 If accept and tft_begin coincide in SHOW or IDLE, SHALL capture into pending registers and go to PENDING.
- Commit waits for the next tft_begin.
REQ-021 SHALL register data_out with a latency of exactly 1 cycle from hcount/lcount.
REQ-022 In IDLE, and in PENDING reached from IDLE, SHALL output BG.
REQ-023 SHALL compute geometry from active bounds as 9-bit unsigned.
- H = Lower-Upper.
- mid = Upper + (H>>1).
- Segment bands are inclusive ranges.
REQ-024 Segment bands SHALL be defined as follows.
- a: rows Upper..Upper+STROKE-1, cols Lift..Right.
- d: rows Lower-STROKE+1..Lower, cols Lift..Right.
- g: rows mid..mid+STROKE-1, cols Lift..Right.
- f: cols Lift..Lift+STROKE-1, rows Upper..mid.
- e: cols Lift..Lift+STROKE-1, rows mid..Lower.
- b: cols Right-STROKE+1..Right, rows Upper..mid.
- c: cols Right-STROKE+1..Right, rows mid..Lower.
REQ-025 SHALL light segments per digit (standard 7-segment).
- 0: abcdef; 1: bc; 2: abdeg; 3: abcdg; 4: bcfg.
- 5: acdfg; 6: acdefg; 7: abc; 8: all; 9: abcdfg.
REQ-026 A pixel SHALL be FG if inside any lit band, else BG.
REQ-027 Digit codes 10..15 SHALL light only g.
- g is visible when frame counter bit BLINK_LOG2 = 0, else BG.
REQ-028 SHALL increment the frame counter (BLINK_LOG2+1 bits) on every tft_begin.
- It wraps at all-ones.
REQ-029 If Right<=Lift, or Lower<=Upper, or H<2*STROKE, the whole frame SHALL output BG (degenerate box).
REQ-030 SHALL evaluate bounds arithmetic without wrap.
- A band edge that would underflow or exceed 9'h1FF is clamped to 0 or 9'h1FF respectively.

Reset
REQ-031 While rst=1 at a clock edge, SHALL set:
- FSM=IDLE
- data_out=BG
- digit_ready=1
- busy=0
- frame counter=0
- all pending and active registers=0
REQ-032 Reset asserted mid-frame or in PENDING SHALL discard the pending digit.
- data_out=BG from the cycle after the reset edge.

Verification
REQ-033 Accept digit 8, box Upper=20, Lower=60, Lift=10, Right=40, then tft_begin -> pixels (10,20), (40,40), (25,40) and (25,60) =00; (25,30)=FF; data_out lags hcount by 1 cycle.
REQ-034 Accept digit 1 with the same box -> (12,30)=FF, (39,30)=00, (25,20)=FF; busy=1 from accept until tft_begin, digit_ready=0 during that time.
REQ-035 In SHOW with digit 3, offer digit 7 mid-frame -> rest of frame still shows 3 (g lit: (25,41)=00); next frame shows 7 ((25,41)=FF).
REQ-036 Digit 12 for 64 frames -> g band =00 in frames 0-31 and =FF in frames 32-63; all other pixels FF.
REQ-037 Box Upper=50, Lower=55, STROKE=4 -> entire frame FF; rst during PENDING -> busy=0, digit_ready=1, output FF next frame.
